// File: rtl/dlx_pkg.sv
// dlx_pkg: opcode constants, state encodings and select codes shared by the
// DLX control FSM and its opcode decoder.
// Build option: DLX_AMO_EN adds the atomic amoadd states and class.
package dlx_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_BEQZ    = 6'h04;
    localparam logic [5:0] OP_BNEZ    = 6'h05;
    localparam logic [5:0] OP_ALUI_LO = 6'h08;
    localparam logic [5:0] OP_ALUI_HI = 6'h0F;
    localparam logic [5:0] OP_JR      = 6'h16;
    localparam logic [5:0] OP_JALR    = 6'h17;
    localparam logic [5:0] OP_LOAD    = 6'h24;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] OP_AMOADD  = 6'h2E;
    localparam logic [5:0] OP_HALT    = 6'h3F;

    // Only this funct group is a valid R-type encoding.
    localparam logic [2:0] FUNCT_HI_OK = 3'b100;

    localparam logic [1:0] PC_SEL_INC = 2'd0;
    localparam logic [1:0] PC_SEL_REL = 2'd1;
    localparam logic [1:0] PC_SEL_REG = 2'd2;

    localparam logic [1:0] ALUB_B   = 2'd0;
    localparam logic [1:0] ALUB_IMM = 2'd1;
    localparam logic [1:0] ALUB_ONE = 2'd2;

    // Encodings are fixed so the debug state value does not depend on the build.
    typedef enum logic [4:0] {
        S_IDLE    = 5'd0,
        S_FETCH   = 5'd1,
        S_DECODE  = 5'd2,
        S_ALU     = 5'd3,
        S_ALUI    = 5'd4,
        S_ADDR    = 5'd5,
        S_LOAD    = 5'd6,
        S_COPY    = 5'd7,
        S_STORE   = 5'd8,
`ifdef DLX_AMO_EN
        S_AMO_RD  = 5'd9,
        S_AMO_ADD = 5'd10,
        S_AMO_WR  = 5'd11,
`endif
        S_WB      = 5'd12,
        S_BRANCH  = 5'd13,
        S_BTAKEN  = 5'd14,
        S_JALR    = 5'd15,
        S_JR      = 5'd16,
        S_HALT    = 5'd17
    } state_e;

    typedef enum logic [3:0] {
        CL_RTYPE = 4'd0,
        CL_ALUI  = 4'd1,
        CL_LOAD  = 4'd2,
        CL_STORE = 4'd3,
        CL_AMO   = 4'd4,
        CL_BEQZ  = 4'd5,
        CL_BNEZ  = 4'd6,
        CL_JR    = 4'd7,
        CL_JALR  = 4'd8,
        CL_HALT  = 4'd9,
        CL_ILL   = 4'd15
    } op_class_e;

endpackage

// File: rtl/dlx_op_decode.sv
// dlx_op_decode: combinational opcode/funct to instruction-class mapping.
// Build option: DLX_AMO_EN makes 0x2E decode as amoadd; otherwise illegal.
module dlx_op_decode
    import dlx_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] op_class,
    output logic       illegal
);

    // Low funct bits select the ALU operation only; they never make an encoding illegal.
    logic funct_unused;
    assign funct_unused = ^funct[2:0];

    // Classify the latched opcode; anything unrecognised is illegal.
    always_comb begin
        op_class = CL_ILL;
        if (opcode == OP_RTYPE) begin
            op_class = (funct[5:3] == FUNCT_HI_OK) ? CL_RTYPE : CL_ILL;
        end else if (opcode >= OP_ALUI_LO && opcode <= OP_ALUI_HI) begin
            op_class = CL_ALUI;
        end else begin
            case (opcode)
                OP_LOAD:   op_class = CL_LOAD;
                OP_SW:     op_class = CL_STORE;
`ifdef DLX_AMO_EN
                OP_AMOADD: op_class = CL_AMO;
`endif
                OP_BEQZ:   op_class = CL_BEQZ;
                OP_BNEZ:   op_class = CL_BNEZ;
                OP_JR:     op_class = CL_JR;
                OP_JALR:   op_class = CL_JALR;
                OP_HALT:   op_class = CL_HALT;
                default:   op_class = CL_ILL;
            endcase
        end
    end

    assign illegal = (op_class == CL_ILL);

endmodule

// File: rtl/dlx_ctrl_fsm.sv
// dlx_ctrl_fsm: multicycle control FSM for one DLX core. Sequences every
// datapath enable and the data-memory request/acknowledge handshake.
// Build option: define DLX_AMO_EN to include the bus-locked amoadd sequence;
// without it bus_lock stays 0 and opcode 0x2E halts as illegal.
module dlx_ctrl_fsm
    import dlx_pkg::*;
#(
    parameter int ST_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [5:0]      Opcode,
    input  logic [5:0]      funct,
    input  logic            a_zero,
    input  logic            mem_ack,
    output logic            IR_en,
    output logic            PC_en,
    output logic            A_en,
    output logic            B_en,
    output logic            C_en,
    output logic            MAR_en,
    output logic            MDR_en,
    output logic            GPR_we,
    output logic [1:0]      pc_sel,
    output logic            alu_a_sel,
    output logic [1:0]      alu_b_sel,
    output logic            alu_add,
    output logic            mdr_sel,
    output logic            mem_req,
    output logic            mem_we,
    output logic            bus_lock,
    output logic            halted,
    output logic [ST_W-1:0] state
);

    state_e     state_q;
    state_e     state_d;
    logic [3:0] op_class;
    logic       illegal;

    dlx_op_decode u_dec (
        .opcode   (Opcode),
        .funct    (funct),
        .op_class (op_class),
        .illegal  (illegal)
    );

    assign state = ST_W'(state_q);

    // State register; reset returns to IDLE without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state. The IR is held from FETCH onward, so the decoded class
    // stays valid for every later state of the same instruction.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (illegal) begin
                    state_d = S_HALT;
                end else begin
                    case (op_class)
                        CL_RTYPE:                   state_d = S_ALU;
                        CL_ALUI:                    state_d = S_ALUI;
                        CL_LOAD, CL_STORE, CL_AMO:  state_d = S_ADDR;
                        CL_BEQZ, CL_BNEZ:           state_d = S_BRANCH;
                        CL_JR:                      state_d = S_JR;
                        CL_JALR:                    state_d = S_JALR;
                        default:                    state_d = S_HALT;
                    endcase
                end
            end
            S_ALU, S_ALUI: state_d = S_WB;
            S_ADDR: begin
                case (op_class)
                    CL_LOAD:  state_d = S_LOAD;
                    CL_STORE: state_d = S_STORE;
`ifdef DLX_AMO_EN
                    CL_AMO:   state_d = S_AMO_RD;
`endif
                    default:  state_d = S_HALT;
                endcase
            end
            S_LOAD:   if (mem_ack) state_d = S_COPY;
            S_COPY:   state_d = S_WB;
            S_STORE:  if (mem_ack) state_d = S_FETCH;
`ifdef DLX_AMO_EN
            S_AMO_RD:  if (mem_ack) state_d = S_AMO_ADD;
            S_AMO_ADD: state_d = S_AMO_WR;
            S_AMO_WR:  if (mem_ack) state_d = S_WB;
`endif
            S_WB:     state_d = S_FETCH;
            S_BRANCH: begin
                if ((op_class == CL_BEQZ && a_zero) || (op_class == CL_BNEZ && !a_zero))
                    state_d = S_BTAKEN;
                else
                    state_d = S_FETCH;
            end
            S_BTAKEN: state_d = S_FETCH;
            S_JALR:   state_d = S_JR;
            S_JR:     state_d = (op_class == CL_JALR) ? S_WB : S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore outputs per state; MDR_en alone also follows mem_ack.
    always_comb begin
        IR_en     = 1'b0;
        PC_en     = 1'b0;
        A_en      = 1'b0;
        B_en      = 1'b0;
        C_en      = 1'b0;
        MAR_en    = 1'b0;
        MDR_en    = 1'b0;
        GPR_we    = 1'b0;
        pc_sel    = PC_SEL_INC;
        alu_a_sel = 1'b0;
        alu_b_sel = ALUB_B;
        alu_add   = 1'b0;
        mdr_sel   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        bus_lock  = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_FETCH:  IR_en = 1'b1;
            S_DECODE: begin
                A_en   = 1'b1;
                B_en   = 1'b1;
                PC_en  = 1'b1;
                pc_sel = PC_SEL_INC;
            end
            S_ALU: begin
                C_en      = 1'b1;
                alu_a_sel = 1'b1;
                alu_b_sel = ALUB_B;
            end
            S_ALUI: begin
                C_en      = 1'b1;
                alu_a_sel = 1'b1;
                alu_b_sel = ALUB_IMM;
            end
            S_ADDR: begin
                MAR_en    = 1'b1;
                alu_add   = 1'b1;
                alu_a_sel = 1'b1;
                alu_b_sel = ALUB_IMM;
            end
            S_LOAD: begin
                mem_req = 1'b1;
                MDR_en  = mem_ack;
            end
            S_COPY:   C_en = 1'b1;
            S_STORE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
`ifdef DLX_AMO_EN
            S_AMO_RD: begin
                mem_req  = 1'b1;
                bus_lock = 1'b1;
                MDR_en   = mem_ack;
            end
            S_AMO_ADD: begin
                bus_lock = 1'b1;
                C_en     = 1'b1;
                alu_add  = 1'b1;
            end
            S_AMO_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                bus_lock = 1'b1;
                mdr_sel  = 1'b1;
            end
`endif
            S_WB:     GPR_we = 1'b1;
            S_BTAKEN: begin
                PC_en  = 1'b1;
                pc_sel = PC_SEL_REL;
            end
            S_JALR: begin
                C_en      = 1'b1;
                alu_a_sel = 1'b0;
            end
            S_JR: begin
                PC_en  = 1'b1;
                pc_sel = PC_SEL_REG;
            end
            S_HALT:   halted = 1'b1;
            default: ;
        endcase
    end

endmodule
